// File: rtl/delivery_bowler.sv
// Delivery generator: a 4-bit LFSR picks each ball's outcome, and an IDLE/GAP/OFFER/HALT FSM
// paces offers to the scorer and counts the legal balls in the current over.
module delivery_bowler #(
    parameter logic [3:0] SEED = 4'b1001,
    parameter int         GAP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ack,
    input  logic       inning_over,
    input  logic       game_over,
    output logic       valid,
    output logic [8:0] outcome,
    output logic       extra,
    output logic [3:0] lfsr_out,
    output logic [2:0] legal_count,
    output logic       over_done
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [3:0] SEED_EFF = (SEED == 4'd0) ? 4'd1 : SEED;
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    // Inclusive LFSR value range for each one-hot outcome bit.
    // Bit order is dotball, single, double, triple, fours, sixes, wideball, noball, wicket.
    localparam logic [3:0] BIN_LO [0:8] = '{4'd1, 4'd4, 4'd7, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
    localparam logic [3:0] BIN_HI [0:8] = '{4'd3, 4'd6, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_OFFER,
        ST_HALT
    } state_t;

    state_t     state_reg;
    logic [3:0] gap_cnt_reg;
    logic [8:0] decoded;
    logic       decoded_extra;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_decode
            assign decoded[gi] = (lfsr_out >= BIN_LO[gi]) && (lfsr_out <= BIN_HI[gi]);
        end
    endgenerate

    assign decoded_extra = decoded[6] | decoded[7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_out <= SEED_EFF;
        end else begin
            lfsr_out <= {lfsr_out[2:0], lfsr_out[3] ^ lfsr_out[2]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= 4'd0;
            valid       <= 1'b0;
            outcome     <= 9'd0;
            extra       <= 1'b0;
            legal_count <= 3'd0;
            over_done   <= 1'b0;
        end else begin
            over_done <= 1'b0;
            if (game_over) begin
                state_reg <= ST_HALT;
                valid     <= 1'b0;
                outcome   <= 9'd0;
                extra     <= 1'b0;
            end else if (inning_over && (state_reg != ST_HALT)) begin
                // Innings ended: any pending offer is dropped uncounted.
                state_reg   <= ST_IDLE;
                gap_cnt_reg <= 4'd0;
                valid       <= 1'b0;
                outcome     <= 9'd0;
                extra       <= 1'b0;
                legal_count <= 3'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (enable) begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= GAP_LOAD;
                        end
                    end
                    ST_GAP: begin
                        if (!enable) begin
                            state_reg   <= ST_IDLE;
                            gap_cnt_reg <= 4'd0;
                        end else if (gap_cnt_reg == 4'd0) begin
                            state_reg <= ST_OFFER;
                            valid     <= 1'b1;
                            outcome   <= decoded;
                            extra     <= decoded_extra;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 4'd1;
                        end
                    end
                    ST_OFFER: begin
                        if (ack) begin
                            valid   <= 1'b0;
                            outcome <= 9'd0;
                            extra   <= 1'b0;
                            if (!extra) begin
                                if (legal_count == 3'd5) begin
                                    legal_count <= 3'd0;
                                    over_done   <= 1'b1;
                                end else begin
                                    legal_count <= legal_count + 3'd1;
                                end
                            end
                            if (enable) begin
                                state_reg   <= ST_GAP;
                                gap_cnt_reg <= GAP_LOAD;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    ST_HALT: begin
                        state_reg <= ST_HALT;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delivery_bowler.sv
// Directed bench for delivery_bowler: reset, LFSR cycle, offer latency, hold, over counting,
// innings end, game end and reset during an offer.
module tb_delivery_bowler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       ack = 1'b0;
    logic       inning_over = 1'b0;
    logic       game_over = 1'b0;
    logic       valid, extra, over_done;
    logic [8:0] outcome;
    logic [3:0] lfsr_out;
    logic [2:0] legal_count;
    logic       z_valid, z_extra, z_over_done;
    logic [8:0] z_outcome;
    logic [3:0] z_lfsr_out;
    logic [2:0] z_legal_count;

    int total = 0;
    int bad   = 0;
    int steps = 0;

    // LFSR states after n steps from seed 9.
    logic [3:0] seq [15] = '{4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7,
                             4'd15, 4'd14, 4'd12, 4'd8, 4'd1, 4'd2, 4'd4};

    // Over scenario: ack edges chosen so that exactly one wideball appears between legal balls.
    int         ack_at  [7] = '{7, 12, 17, 30, 35, 40, 45};
    logic [8:0] exp_out [7] = '{9'h010, 9'h020, 9'h008, 9'h002, 9'h040, 9'h100, 9'h001};
    logic       exp_ext [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_lc  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    logic       exp_od  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    delivery_bowler dut (
        .clk(clk), .reset(reset), .enable(enable), .ack(ack),
        .inning_over(inning_over), .game_over(game_over),
        .valid(valid), .outcome(outcome), .extra(extra), .lfsr_out(lfsr_out),
        .legal_count(legal_count), .over_done(over_done)
    );

    delivery_bowler #(.SEED(4'd0)) dut_zero (
        .clk(clk), .reset(reset), .enable(enable), .ack(ack),
        .inning_over(inning_over), .game_over(game_over),
        .valid(z_valid), .outcome(z_outcome), .extra(z_extra), .lfsr_out(z_lfsr_out),
        .legal_count(z_legal_count), .over_done(z_over_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        steps++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        ack = 1'b0;
        inning_over = 1'b0;
        game_over = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        steps = 0;
    endtask

    task automatic wait_valid(input int bound, output int edges);
        edges = 0;
        while (valid !== 1'b1 && edges < bound) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            ack = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;
        #2;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", valid); end
        total++; if (outcome !== 9'd0) begin bad++; $display("FAIL reset_outcome got=%h want=000", outcome); end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL reset_extra got=%0b want=0", extra); end
        total++; if (over_done !== 1'b0) begin bad++; $display("FAIL reset_over_done got=%0b want=0", over_done); end
        total++; if (legal_count !== 3'd0) begin bad++; $display("FAIL reset_legal_count got=%0d want=0", legal_count); end
        total++; if (lfsr_out !== 4'd9) begin bad++; $display("FAIL reset_lfsr got=%0d want=9", lfsr_out); end
        total++; if (z_lfsr_out !== 4'd1) begin bad++; $display("FAIL reset_lfsr_seed0 got=%0d want=1", z_lfsr_out); end
        $display("test_reset: async reset after random activity checked");
    endtask

    task automatic test_lfsr();
        logic [15:0] seen;
        do_reset();
        seen = 16'd0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen[lfsr_out] = 1'b1;
            total++;
            if (lfsr_out !== seq[steps % 15]) begin
                bad++; $display("FAIL lfsr_step%0d got=%0d want=%0d", steps, lfsr_out, seq[steps % 15]);
            end
        end
        total++; if (lfsr_out !== 4'd9) begin bad++; $display("FAIL lfsr_period got=%0d want=9", lfsr_out); end
        total++; if (seen !== 16'hFFFE) begin bad++; $display("FAIL lfsr_visited got=%h want=fffe", seen); end
        total++; if (z_lfsr_out !== 4'd1) begin bad++; $display("FAIL lfsr_seed0_period got=%0d want=1", z_lfsr_out); end
        $display("test_lfsr: 15-step cycle checked");
    endtask

    task automatic test_latency();
        int edges;
        do_reset();
        ack = 1'b1;
        enable = 1'b1;
        wait_valid(20, edges);
        total++; if (edges !== 5) begin bad++; $display("FAIL latency_edges got=%0d want=5", edges); end
        total++; if (outcome !== 9'h010) begin bad++; $display("FAIL latency_outcome got=%h want=010", outcome); end
        total++; if ($countones(outcome) !== 1) begin bad++; $display("FAIL latency_onehot got=%h want=one bit", outcome); end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL latency_extra got=%0b want=0", extra); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_ack_valid got=%0b want=0", valid); end
        total++; if (legal_count !== 3'd1) begin bad++; $display("FAIL latency_count got=%0d want=1", legal_count); end
        wait_valid(20, edges);
        total++; if (edges !== 4) begin bad++; $display("FAIL latency_reload_edges got=%0d want=4", edges); end
        total++; if (outcome !== 9'h080) begin bad++; $display("FAIL latency_noball got=%h want=080", outcome); end
        total++; if (extra !== 1'b1) begin bad++; $display("FAIL latency_noball_extra got=%0b want=1", extra); end
        tick();
        total++; if (outcome !== 9'd0 || extra !== 1'b0) begin bad++; $display("FAIL latency_cleared got=%h/%0b want=000/0", outcome, extra); end
        total++; if (legal_count !== 3'd1) begin bad++; $display("FAIL latency_extra_count got=%0d want=1", legal_count); end
        $display("test_latency: offer timing and decode checked");
    endtask

    task automatic test_hold();
        int edges;
        do_reset();
        ack = 1'b0;
        enable = 1'b1;
        wait_valid(20, edges);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL hold_start got=%0b want=1", valid); end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) enable = 1'b0;
            tick();
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%0b want=1", i, valid); end
            total++; if (outcome !== 9'h010) begin bad++; $display("FAIL hold_outcome cyc=%0d got=%h want=010", i, outcome); end
            total++;
            if (lfsr_out !== seq[steps % 15]) begin
                bad++; $display("FAIL hold_lfsr cyc=%0d got=%0d want=%0d", i, lfsr_out, seq[steps % 15]);
            end
        end
        ack = 1'b1;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_ack_valid got=%0b want=0", valid); end
        total++; if (legal_count !== 3'd1) begin bad++; $display("FAIL hold_ack_count got=%0d want=1", legal_count); end
        for (int i = 0; i < 6; i++) tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_idle_valid got=%0b want=0", valid); end
        total++; if (legal_count !== 3'd1) begin bad++; $display("FAIL hold_stray_ack got=%0d want=1", legal_count); end
        ack = 1'b0;
        $display("test_hold: 20-cycle held offer checked");
    endtask

    task automatic test_over();
        int edges;
        do_reset();
        enable = 1'b1;
        ack = 1'b0;
        for (int k = 0; k < 7; k++) begin
            wait_valid(40, edges);
            total++; if (outcome !== exp_out[k]) begin bad++; $display("FAIL over_outcome%0d got=%h want=%h", k, outcome, exp_out[k]); end
            total++; if (extra !== exp_ext[k]) begin bad++; $display("FAIL over_extra%0d got=%0b want=%0b", k, extra, exp_ext[k]); end
            while (steps < ack_at[k] - 1) tick();
            ack = 1'b1;
            tick();
            ack = 1'b0;
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL over_valid%0d got=%0b want=0", k, valid); end
            total++; if (legal_count !== exp_lc[k]) begin bad++; $display("FAIL over_count%0d got=%0d want=%0d", k, legal_count, exp_lc[k]); end
            total++; if (over_done !== exp_od[k]) begin bad++; $display("FAIL over_done%0d got=%0b want=%0b", k, over_done, exp_od[k]); end
            tick();
            total++; if (over_done !== 1'b0) begin bad++; $display("FAIL over_pulse_len%0d got=%0b want=0", k, over_done); end
            $display("test_over: ball %0d outcome=%h legal_count=%0d", k, exp_out[k], legal_count);
        end
    endtask

    task automatic test_inning();
        int  edges;
        logic any_valid;
        do_reset();
        enable = 1'b1;
        ack = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        total++; if (legal_count !== 3'd2) begin bad++; $display("FAIL inning_precount got=%0d want=2", legal_count); end
        ack = 1'b0;
        wait_valid(20, edges);
        total++; if (outcome !== 9'h010) begin bad++; $display("FAIL inning_offer got=%h want=010", outcome); end
        inning_over = 1'b1;
        tick();
        total++; if (valid !== 1'b0 || outcome !== 9'd0) begin bad++; $display("FAIL inning_withdraw got=%0b/%h want=0/000", valid, outcome); end
        total++; if (legal_count !== 3'd0) begin bad++; $display("FAIL inning_count got=%0d want=0", legal_count); end
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            any_valid |= valid;
        end
        total++; if (any_valid !== 1'b0) begin bad++; $display("FAIL inning_blocked got=%0b want=0", any_valid); end
        inning_over = 1'b0;
        wait_valid(20, edges);
        total++; if (edges !== 5) begin bad++; $display("FAIL inning_relaunch got=%0d want=5", edges); end
        $display("test_inning: withdraw and relaunch checked");
    endtask

    task automatic test_game_over();
        int  edges;
        logic any_valid;
        do_reset();
        enable = 1'b1;
        ack = 1'b0;
        wait_valid(20, edges);
        ack = 1'b1;
        game_over = 1'b1;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL game_valid got=%0b want=0", valid); end
        total++; if (legal_count !== 3'd0) begin bad++; $display("FAIL game_count got=%0d want=0", legal_count); end
        game_over = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_valid |= valid;
        end
        total++; if (any_valid !== 1'b0) begin bad++; $display("FAIL game_halt got=%0b want=0", any_valid); end
        ack = 1'b0;
        $display("test_game_over: halt checked");
    endtask

    task automatic test_reset_mid_offer();
        int edges;
        do_reset();
        enable = 1'b1;
        ack = 1'b0;
        wait_valid(20, edges);
        reset = 1'b0;
        #2;
        total++; if (valid !== 1'b0 || outcome !== 9'd0) begin bad++; $display("FAIL midrst_drop got=%0b/%h want=0/000", valid, outcome); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        steps = 0;
        wait_valid(20, edges);
        total++; if (edges !== 5) begin bad++; $display("FAIL midrst_relaunch got=%0d want=5", edges); end
        total++; if (outcome !== 9'h010) begin bad++; $display("FAIL midrst_outcome got=%h want=010", outcome); end
        total++; if (legal_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", legal_count); end
        $display("test_reset_mid_offer: dropped offer checked");
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_latency();
        test_hold();
        test_over();
        test_inning();
        test_game_over();
        test_reset_mid_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delivery_bowler.md
DELIVERY_BOWLER -- requirements
Module: delivery_bowler

Interface
REQ-001 SHALL have parameter SEED, default 4'b1001, initial LFSR state; SEED of 0 is replaced by 4'b0001.
REQ-002 SHALL have parameter GAP, default 4, number of cycles spent in GAP state before each offer; legal range 1-15.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits new deliveries to be launched.
REQ-006 SHALL have port ack  input  1  scorer accepts the current offer; only meaningful while valid=1.
REQ-007 SHALL have port inning_over  input  1  level from scorer; the innings has ended.
REQ-008 SHALL have port game_over  input  1  level from scorer; the match has ended.
REQ-009 SHALL have port valid  output  1  delivery offer present.
REQ-010 SHALL have port outcome  output  9  one-hot, bit order {wicket,noball,wideball,sixes,fours,triple,double,single,dotball}.
REQ-011 SHALL have port extra  output  1  high with valid when outcome is wideball or noball.
REQ-012 SHALL have port lfsr_out  output  4  current LFSR state.
REQ-013 SHALL have port legal_count  output  3  legal balls accepted in current over, 0-5.
REQ-014 SHALL have port over_done  output  1  one-cycle pulse on completion of a six-legal-ball over.

Function
REQ-015 LFSR SHALL free-run every cycle out of reset: next = {q[2:0], q[3]^q[2]}; period 15; never 0.
REQ-016 Decode of LFSR value v SHALL be: 1-3 dotball, 4-6 single, 7-8 double, 9 triple, 10-11 fours, 12 sixes, 13 wideball, 14 noball, 15 wicket.
REQ-017 FSM states SHALL be IDLE, GAP, OFFER, HALT.
REQ-018 IDLE -> GAP when enable=1, inning_over=0, game_over=0; gap counter loaded with GAP-1 on entry.
REQ-019 GAP: counter decrements each cycle; at counter 0 -> OFFER, registering outcome = decode(lfsr_out of that cycle); total GAP cycles = GAP.
REQ-020 GAP -> IDLE if enable=0; counter discarded.
REQ-021 OFFER: valid=1; outcome and extra SHALL stay stable until the cycle ack=1 is sampled.
REQ-022 enable=0 during OFFER SHALL NOT withdraw the offer.
REQ-023 ack=1 in OFFER: valid=0 next cycle; next state GAP (reload) if enable=1, else IDLE.
REQ-024 Accepted non-extra outcome SHALL increment legal_count; at 5 it wraps to 0 and over_done pulses for exactly the following cycle.
REQ-025 Accepted extra SHALL leave legal_count unchanged.
REQ-026 inning_over=1 in any state except HALT -> IDLE next cycle, valid=0, legal_count=0; offer withdrawn without acceptance; relaunch requires inning_over=0.
REQ-027 game_over=1 in any state -> HALT next cycle, valid=0; HALT exits only by reset; game_over has priority over inning_over and ack in the same cycle.
REQ-028 valid=0 SHALL force outcome=0 and extra=0.
REQ-029 ack while valid=0 SHALL be ignored.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE, valid=0, outcome=0, extra=0, over_done=0, legal_count=0, lfsr_out=SEED (9 by default), gap counter 0.
REQ-031 Reset mid-OFFER SHALL drop the offer without counting it; first offer after release follows REQ-018/019 timing.

Verification
REQ-032 Reset asserted after random activity -> all outputs at REQ-030 values same cycle, lfsr_out=9.
REQ-033 GAP=4, ack tied 1, enable rises: valid rises 5 edges after enable sampled high; outcome equals decode(lfsr_out) from the preceding cycle; exactly one bit set.
REQ-034 ack held 0 for 20 cycles during OFFER -> valid=1 and outcome unchanged all 20 cycles while lfsr_out keeps stepping.
REQ-035 Six legal acks with one wideball accepted between them -> legal_count 1,2,3,4,5 then 0, over_done single pulse after the sixth legal ack only.
REQ-036 game_over=1 with ack=1 in OFFER -> valid=0 next cycle, legal_count unchanged, no further offers despite enable=1 until reset.
REQ-037 Free-run 15 cycles from reset -> lfsr_out returns to 9, visits 15 distinct nonzero values; SEED=0 instance starts at 1.
